ksi_window_seq: RTL and testbench

Two-pass window sequencer that sits directly upstream of the KSI statistics stage. It takes the filtered K1/K2 real-part sample stream and frames it into windows of `L_stroke` samples. Each sample is forwarded immediately for the first pass (mean accumulation). The window is stored in a ping-pong buffer and replayed once the mean is valid, for the second pass (deviation, square, accumulate). It also produces the window-framing strobes the KSI stage consumes.

---
 rtl/ksi_window_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_ksi_window_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksi_window_seq.sv
// Two-pass window sequencer: forwards each sample for mean accumulation and stores the
// window in a ping-pong RAM, then replays it once the mean is available.
module ksi_window_seq #(
  parameter int MEAN_LAT = 8,
  parameter int AW       = 12
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        work,
  input  logic        d_valid,
  input  logic [31:0] filt_k1_re,
  input  logic [31:0] filt_k2_re,
  input  logic [11:0] l_stroke,
  output logic        acc1_en,
  output logic        acc1_new,
  output logic [31:0] acc1_k1,
  output logic [31:0] acc1_k2,
  output logic [11:0] l_win,
  output logic        rep_valid,
  output logic        rep_first,
  output logic        rep_last,
  output logic [31:0] rep_k1,
  output logic [31:0] rep_k2,
  output logic [11:0] rep_l,
  output logic        win_done,
  output logic        ovf
);
  localparam int CW = $clog2(MEAN_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH} state_t;

  state_t        state_q, state_d;
  logic          rd_bank_q, rd_bank_d, wr_bank_q, wr_bank_d;
  logic [11:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic          flush_cnt_q, flush_cnt_d;
  logic [1:0]    full_q, full_d;
  logic [CW-1:0] rdy_cnt_q [2];
  logic [CW-1:0] rdy_cnt_d [2];
  logic [11:0]   l_eff_q [2];
  logic [11:0]   l_eff_d [2];
  logic          ovf_q, ovf_d;
  logic          acc1_en_q, acc1_en_d, acc1_new_q, acc1_new_d;
  logic [31:0]   acc1_k1_q, acc1_k1_d, acc1_k2_q, acc1_k2_d;
  logic          p1_valid_q, p1_valid_d, p1_first_q, p1_first_d, p1_last_q, p1_last_d;
  logic [11:0]   p1_l_q, p1_l_d;
  logic          rep_valid_q, rep_valid_d, rep_first_q, rep_first_d, rep_last_q, rep_last_d;
  logic [31:0]   rep_k1_q, rep_k1_d, rep_k2_q, rep_k2_d;
  logic [11:0]   rep_l_q, rep_l_d;
  logic          win_done_q, win_done_d;

  logic [1:0]    ready;
  logic          free_pulse, rd_en, rd_sel, rd_first, rd_last;
  logic [11:0]   rd_addr;
  logic          wr_free, accept, last_wr;
  logic [11:0]   l_new, l_cur;

  logic [63:0]   mem [2**(AW+1)];
  logic [63:0]   ram_rd_q;

  assign ready[0] = full_q[0] && (rdy_cnt_q[0] == '0);
  assign ready[1] = full_q[1] && (rdy_cnt_q[1] == '0);

  // Read side: the first address of a window is issued in the cycle its bank turns ready.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    flush_cnt_d = flush_cnt_q;
    rd_en       = 1'b0;
    rd_sel      = rd_bank_q;
    rd_addr     = rd_cnt_q;
    rd_first    = 1'b0;
    rd_last     = 1'b0;
    free_pulse  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready[rd_bank_q]) begin
          rd_en    = 1'b1;
          rd_addr  = 12'd0;
          rd_first = 1'b1;
          rd_cnt_d = 12'd1;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        rd_en = 1'b1;
        if (rd_cnt_q == l_eff_q[rd_bank_q] - 12'd1) begin
          rd_last     = 1'b1;
          flush_cnt_d = 1'b0;
          state_d     = S_FLUSH;
        end else begin
          rd_cnt_d = rd_cnt_q + 12'd1;
        end
      end
      S_FLUSH: begin
        if (!flush_cnt_q) begin
          flush_cnt_d = 1'b1;
        end else begin
          free_pulse = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          state_d    = S_IDLE;
          // Chain straight into the other bank when it is already waiting.
          if (ready[~rd_bank_q]) begin
            rd_en    = 1'b1;
            rd_sel   = ~rd_bank_q;
            rd_addr  = 12'd0;
            rd_first = 1'b1;
            rd_cnt_d = 12'd1;
            state_d  = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!work) begin
      state_d     = S_IDLE;
      rd_bank_d   = 1'b0;
      rd_cnt_d    = 12'd0;
      flush_cnt_d = 1'b0;
    end
  end

  // Write side and per-bank bookkeeping; a bank released this cycle is already writable.
  always_comb begin
    wr_free = !full_q[wr_bank_q] || (free_pulse && (rd_bank_q == wr_bank_q));
    accept  = work && d_valid && wr_free;
    l_new   = (l_stroke < 12'd2) ? 12'd2 : l_stroke;
    l_cur   = (wr_cnt_q == 12'd0) ? l_new : l_eff_q[wr_bank_q];
    last_wr = accept && (wr_cnt_q == l_cur - 12'd1);
    full_d  = full_q;
    for (int b = 0; b < 2; b++) begin
      rdy_cnt_d[b] = (rdy_cnt_q[b] != '0) ? rdy_cnt_q[b] - CW'(1) : '0;
      l_eff_d[b]   = l_eff_q[b];
    end
    if (free_pulse) full_d[rd_bank_q] = 1'b0;
    if (accept && (wr_cnt_q == 12'd0)) l_eff_d[wr_bank_q] = l_new;
    if (last_wr) begin
      full_d[wr_bank_q]    = 1'b1;
      rdy_cnt_d[wr_bank_q] = CW'(MEAN_LAT);
    end
    wr_cnt_d  = accept ? (last_wr ? 12'd0 : wr_cnt_q + 12'd1) : wr_cnt_q;
    wr_bank_d = last_wr ? ~wr_bank_q : wr_bank_q;
    ovf_d     = ovf_q || (work && d_valid && !wr_free);
    if (!work) begin
      full_d    = 2'b00;
      rdy_cnt_d = '{default: '0};
      wr_cnt_d  = 12'd0;
      wr_bank_d = 1'b0;
      ovf_d     = 1'b0;
    end
  end

  always_comb begin
    acc1_en_d   = accept;
    acc1_new_d  = accept && (wr_cnt_q == 12'd0);
    acc1_k1_d   = accept ? filt_k1_re : acc1_k1_q;
    acc1_k2_d   = accept ? filt_k2_re : acc1_k2_q;
    p1_valid_d  = rd_en && work;
    p1_first_d  = rd_first && work;
    p1_last_d   = rd_last && work;
    p1_l_d      = rd_en ? l_eff_q[rd_sel] : p1_l_q;
    rep_valid_d = p1_valid_q && work;
    rep_first_d = p1_first_q && work;
    rep_last_d  = p1_last_q && work;
    rep_k1_d    = rep_valid_d ? ram_rd_q[63:32] : rep_k1_q;
    rep_k2_d    = rep_valid_d ? ram_rd_q[31:0] : rep_k2_q;
    rep_l_d     = rep_valid_d ? p1_l_q : rep_l_q;
    win_done_d  = rep_last_q && work;
  end

  // Window storage; bank select is the top address bit.
  always_ff @(posedge clk) begin
    if (accept) mem[{wr_bank_q, wr_cnt_q[AW-1:0]}] <= {filt_k1_re, filt_k2_re};
    ram_rd_q <= mem[{rd_sel, rd_addr[AW-1:0]}];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_cnt_q    <= 12'd0;
      wr_cnt_q    <= 12'd0;
      flush_cnt_q <= 1'b0;
      full_q      <= 2'b00;
      rdy_cnt_q   <= '{default: '0};
      l_eff_q     <= '{default: '0};
      ovf_q       <= 1'b0;
      acc1_en_q   <= 1'b0;
      acc1_new_q  <= 1'b0;
      acc1_k1_q   <= 32'd0;
      acc1_k2_q   <= 32'd0;
      p1_valid_q  <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      p1_l_q      <= 12'd0;
      rep_valid_q <= 1'b0;
      rep_first_q <= 1'b0;
      rep_last_q  <= 1'b0;
      rep_k1_q    <= 32'd0;
      rep_k2_q    <= 32'd0;
      rep_l_q     <= 12'd0;
      win_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      wr_bank_q   <= wr_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      full_q      <= full_d;
      rdy_cnt_q   <= rdy_cnt_d;
      l_eff_q     <= l_eff_d;
      ovf_q       <= ovf_d;
      acc1_en_q   <= acc1_en_d;
      acc1_new_q  <= acc1_new_d;
      acc1_k1_q   <= acc1_k1_d;
      acc1_k2_q   <= acc1_k2_d;
      p1_valid_q  <= p1_valid_d;
      p1_first_q  <= p1_first_d;
      p1_last_q   <= p1_last_d;
      p1_l_q      <= p1_l_d;
      rep_valid_q <= rep_valid_d;
      rep_first_q <= rep_first_d;
      rep_last_q  <= rep_last_d;
      rep_k1_q    <= rep_k1_d;
      rep_k2_q    <= rep_k2_d;
      rep_l_q     <= rep_l_d;
      win_done_q  <= win_done_d;
    end
  end

  assign acc1_en   = acc1_en_q;
  assign acc1_new  = acc1_new_q;
  assign acc1_k1   = acc1_k1_q;
  assign acc1_k2   = acc1_k2_q;
  assign l_win     = l_eff_q[wr_bank_q];
  assign rep_valid = rep_valid_q;
  assign rep_first = rep_first_q;
  assign rep_last  = rep_last_q;
  assign rep_k1    = rep_k1_q;
  assign rep_k2    = rep_k2_q;
  assign rep_l     = rep_l_q;
  assign win_done  = win_done_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_ksi_window_seq.sv
// Scoreboard bench for ksi_window_seq: a window-level model predicts acc1, replay and
// win_done events with their cycle numbers; a negedge monitor pops and compares them.
module tb_ksi_window_seq;
  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        clr, work, d_valid;
  logic [31:0] k1_in, k2_in;
  logic [11:0] ls_in;
  logic        acc1_en, acc1_new, rep_valid, rep_first, rep_last, win_done, ovf;
  logic [31:0] acc1_k1, acc1_k2, rep_k1, rep_k2;
  logic [11:0] l_win, rep_l;

  ksi_window_seq #(.MEAN_LAT(ML), .AW(12)) dut (
    .clk(clk), .clr(clr), .work(work), .d_valid(d_valid),
    .filt_k1_re(k1_in), .filt_k2_re(k2_in), .l_stroke(ls_in),
    .acc1_en(acc1_en), .acc1_new(acc1_new), .acc1_k1(acc1_k1), .acc1_k2(acc1_k2),
    .l_win(l_win), .rep_valid(rep_valid), .rep_first(rep_first), .rep_last(rep_last),
    .rep_k1(rep_k1), .rep_k2(rep_k2), .rep_l(rep_l), .win_done(win_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int t; logic [63:0] d; bit first; logic [11:0] l; bit chk_l;} acc_t;
  typedef struct {int t; logic [63:0] d; bit first; bit last; logic [11:0] l;} rep_t;
  acc_t acc_q[$];
  rep_t rep_q[$];
  int   done_q[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Window-level reference model, indexed by clock edge number.
  int          free_edge [2];
  bit          m_wbank;
  logic [63:0] m_win[$];
  int          m_leff;
  bit          m_ovf;
  int          rd_avail;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_clear();
    free_edge[0] = 0;
    free_edge[1] = 0;
    m_wbank = 1'b0;
    m_win.delete();
    m_leff = 2;
    m_ovf = 1'b0;
    rd_avail = 0;
  endfunction

  // Forget every predicted event from cycle c onward (abort or reset cancels them).
  function automatic void purge(input int c);
    while (acc_q.size() != 0 && acc_q[$].t >= c) void'(acc_q.pop_back());
    while (rep_q.size() != 0 && rep_q[$].t >= c) void'(rep_q.pop_back());
    while (done_q.size() != 0 && done_q[$] >= c) void'(done_q.pop_back());
  endfunction

  task automatic model_step(input int e, input bit v, input logic [31:0] a, input logic [31:0] b,
                            input logic [11:0] ls, input bit w);
    acc_t ae;
    rep_t re;
    int   s;
    if (!w) begin
      purge(e);
      model_clear();
      return;
    end
    if (!v) return;
    if (free_edge[m_wbank] > e) begin
      m_ovf = 1'b1;
      return;
    end
    if (m_win.size() == 0) m_leff = (ls < 12'd2) ? 2 : int'(ls);
    ae.t = e;
    ae.d = {a, b};
    ae.first = (m_win.size() == 0);
    ae.l = 12'(m_leff);
    ae.chk_l = (m_win.size() != m_leff - 1);
    acc_q.push_back(ae);
    m_win.push_back({a, b});
    if (m_win.size() == m_leff) begin
      // Replay starts when the mean latency has elapsed and the reader has finished the previous window.
      s = imax(e + ML + 1, rd_avail);
      for (int i = 0; i < m_leff; i++) begin
        re.t = s + 1 + i;
        re.d = m_win[i];
        re.first = (i == 0);
        re.last = (i == m_leff - 1);
        re.l = 12'(m_leff);
        rep_q.push_back(re);
      end
      done_q.push_back(s + m_leff + 1);
      rd_avail = s + m_leff + 1;
      free_edge[m_wbank] = rd_avail;
      m_wbank = !m_wbank;
      m_win.delete();
    end
  endtask

  // Called 1 time unit after a rising edge; applies inputs for the next edge.
  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [11:0] ls, input bit w);
    work = w;
    d_valid = v;
    k1_in = a;
    k2_in = b;
    ls_in = ls;
    model_step(cyc + 1, v, a, b, ls, w);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [11:0] ls);
    repeat (n) drive(1'b0, 32'd0, 32'd0, ls, 1'b1);
  endtask

  task automatic async_reset();
    d_valid = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    chk("rst_acc1_en", acc1_en, 0);
    chk("rst_acc1_k1", acc1_k1, 0);
    chk("rst_l_win", l_win, 0);
    chk("rst_rep_k1", rep_k1, 0);
    chk("rst_rep_l", rep_l, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rep_valid", rep_valid, 0);
    purge(cyc);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    acc_t ae;
    rep_t re;
    int   dt;
    if (acc1_en) begin
      if (acc_q.size() == 0) chk("acc1_extra", acc1_en, 0);
      else begin
        ae = acc_q.pop_front();
        chk("acc1_cycle", cyc, ae.t);
        chk("acc1_data", {acc1_k1, acc1_k2}, ae.d);
        chk("acc1_new", acc1_new, ae.first);
        if (ae.chk_l) chk("l_win", l_win, ae.l);
      end
    end
    if (rep_valid) begin
      if (rep_q.size() == 0) chk("rep_extra", rep_valid, 0);
      else begin
        re = rep_q.pop_front();
        chk("rep_cycle", cyc, re.t);
        chk("rep_data", {rep_k1, rep_k2}, re.d);
        chk("rep_first_last", {rep_first, rep_last}, {re.first, re.last});
        chk("rep_l", rep_l, re.l);
      end
    end
    if (win_done) begin
      if (done_q.size() == 0) chk("win_done_extra", win_done, 0);
      else begin
        dt = done_q.pop_front();
        chk("win_done_cycle", cyc, dt);
      end
    end
  end

  logic [31:0] basic [4];
  int          n;
  logic [11:0] ls;

  initial begin
    basic[0] = 32'h3f80_0000;
    basic[1] = 32'h4000_0000;
    basic[2] = 32'h4040_0000;
    basic[3] = 32'h4080_0000;
    clr = 1'b0;
    work = 1'b0;
    d_valid = 1'b0;
    k1_in = 32'd0;
    k2_in = 32'd0;
    ls_in = 12'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rep_valid", rep_valid, 0);
    chk("reset_acc1_en", acc1_en, 0);
    chk("reset_win_done", win_done, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_data", {acc1_k1, rep_k2}, 0);
    chk("reset_lengths", {l_win, rep_l}, 0);
    clr = 1'b1;

    // Basic window of four samples at half duty.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, basic[i], basic[i] ^ 32'h8000_0000, 12'd4, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 12'd4, 1'b1);
    end
    idle(20, 12'd4);

    // Length clamp: 0 and 1 both give two-sample windows.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, $urandom, (i < 2) ? 12'd0 : 12'd1, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 12'd1, 1'b1);
    end
    idle(30, 12'd1);

    // Ping-pong: l_stroke only matters on a window's first sample.
    for (int i = 0; i < 48; i++) begin
      ls = (m_win.size() == 0) ? 12'd16 : 12'($urandom_range(0, 4095));
      drive(1'b1, $urandom, $urandom, ls, 1'b1);
      drive(1'b0, 32'd0, 32'd0, ls, 1'b1);
    end
    idle(70, 12'd16);
    chk("ovf_pingpong", ovf, 0);

    // Overflow under continuous input.
    for (int i = 0; i < 40; i++) drive(1'b1, $urandom, $urandom, 12'd4, 1'b1);
    idle(60, 12'd4);
    chk("ovf_overflow", ovf, m_ovf);

    // Abort during replay.
    n = 0;
    do begin
      drive(1'b1, $urandom, $urandom, 12'd4, 1'b1);
      n++;
    end while (!(rep_valid && n >= 12) && n < 60);
    chk("abort_replay_seen", rep_valid, 1);
    drive(1'b0, 32'd0, 32'd0, 12'd4, 1'b0);
    chk("abort_rep_valid", rep_valid, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_win_done", win_done, 0);
    idle(2, 12'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, $urandom, 12'd4, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 12'd4, 1'b1);
    end
    idle(25, 12'd4);

    // Asynchronous reset while filling with overflow pending.
    for (int i = 0; i < 20; i++) drive(1'b1, $urandom, $urandom, 12'd4, 1'b1);
    async_reset();
    idle(40, 12'd4);

    // Random traffic with occasional aborts.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 2) != 0, $urandom, $urandom, 12'($urandom_range(0, 10)),
            $urandom_range(0, 99) != 0);
    idle(80, 12'd4);
    chk("ovf_random", ovf, m_ovf);

    chk("acc1_pending", acc_q.size(), 0);
    chk("rep_pending", rep_q.size(), 0);
    chk("win_done_pending", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
